// File: rtl/rca16_serial_sub_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
//   start, a, b, bin : request and operands, driven by the requester (master)
//   busy, done       : progress and one-cycle completion pulse, driven by the subtractor (slave)
//   d, bout, ov      : difference, borrow-out and signed overflow of the last completed operation
interface rca16_serial_sub_if #(
   parameter int W = 16
) ();
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [W-1:0] d;
   logic         bout;
   logic         ov;

   modport master (
      output start, a, b, bin,
      input  busy, done, d, bout, ov
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, d, bout, ov
   );
endinterface

// File: rtl/rca16_serial_sub.sv
// Bit-serial two's-complement subtractor: d = a - b - bin, one bit per clock,
// LSB first, through a single full-subtractor cell.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset, aborts any operation in flight
//   bus : slave side of rca16_serial_sub_if
//         start/a/b/bin accepted only while idle; busy high for W cycles;
//         done pulses once with d/bout/ov, which then hold until the next
//         completion or reset.
module rca16_serial_sub #(
   parameter int W = 16
) (
   input logic               clk,
   input logic               rst,
   rca16_serial_sub_if.slave bus
);
   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state;
   logic [W-1:0]  a_sh;
   logic [W-1:0]  b_sh;
   logic [W-1:0]  res;
   logic          br;
   logic [CW-1:0] cnt;
   logic          diff_bit;
   logic          br_next;

   // Full-subtractor cell: returns {borrow_out, diff}.
   function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
      full_sub = {(~x & y) | (~x & bi) | (y & bi), x ^ y ^ bi};
   endfunction

   // Operands are shifted right each cycle, so bit 0 is always the current bit.
   always_comb begin
      {br_next, diff_bit} = full_sub(a_sh[0], b_sh[0], br);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.d    <= '0;
         bus.bout <= 1'b0;
         bus.ov   <= 1'b0;
         a_sh     <= '0;
         b_sh     <= '0;
         res      <= '0;
         br       <= 1'b0;
         cnt      <= '0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_sh     <= bus.a;
                  b_sh     <= bus.b;
                  br       <= bus.bin;
                  cnt      <= '0;
                  state    <= RUN;
                  bus.busy <= 1'b1;
               end
            end
            RUN: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               // Difference bits enter at the MSB; after W shifts bit 0 sits at res[0].
               res  <= {diff_bit, res[W-1:1]};
               br   <= br_next;
               cnt  <= cnt + 1'b1;
               if (cnt == LAST) begin
                  bus.d    <= {diff_bit, res[W-1:1]};
                  bus.bout <= br_next;
                  // Overflow: borrow out of the sign bit differs from borrow into it.
                  bus.ov   <= br_next ^ br;
                  bus.done <= 1'b1;
                  bus.busy <= 1'b0;
                  cnt      <= '0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rca16_serial_sub.sv
module tb_rca16_serial_sub;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;
   bit   chk_en = 1'b0;

   always #5 clk = ~clk;

   rca16_serial_sub_if #(.W(W)) bus ();

   rca16_serial_sub #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- behavioural reference model ----------------
   bit           m_busy, m_done, m_bout, m_ov;
   bit [W-1:0]   m_d;
   int           m_left;
   bit [W-1:0]   p_d;
   bit           p_bout, p_ov;

   function automatic void predict(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                                   output bit [W-1:0] rd, output bit rb, output bit ro);
      logic [W:0] wide;
      longint     sd;
      wide = {1'b0, x} - {1'b0, y} - (W+1)'(bi);
      rd   = wide[W-1:0];
      rb   = wide[W];
      sd   = longint'($signed(x)) - longint'($signed(y)) - longint'(bi);
      ro   = (sd > (longint'(1) << (W-1)) - 1) || (sd < -(longint'(1) << (W-1)));
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_busy = 0; m_done = 0; m_d = '0; m_bout = 0; m_ov = 0; m_left = 0;
      end else begin
         m_done = 0;
         if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 0; m_done = 1;
               m_d = p_d; m_bout = p_bout; m_ov = p_ov;
            end
         end else if (bus.start) begin
            predict(bus.a, bus.b, bus.bin, p_d, p_bout, p_ov);
            m_busy = 1;
            m_left = W;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: every cycle once reset has been applied.
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", 32'(bus.busy), 32'(m_busy));
         check("done", 32'(bus.done), 32'(m_done));
         check("d",    32'(bus.d),    32'(m_d));
         check("bout", 32'(bus.bout), 32'(m_bout));
         check("ov",   32'(bus.ov),   32'(m_ov));
      end
   end

   // ---------------- directed operation ----------------
   // Entered and left at a negedge; start is driven at once so back-to-back works.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                         input logic [W-1:0] ed, input logic eb, input logic eo,
                         input int ignore_at);
      int busy_cnt;
      bit got;
      bit [W-1:0] md;
      bit mb, mo;
      predict(ta, tb, tbin, md, mb, mo);
      check("model_d", 32'(md), 32'(ed));
      check("model_bout", 32'(mb), 32'(eb));
      check("model_ov", 32'(mo), 32'(eo));
      bus.start = 1; bus.a = ta; bus.b = tb; bus.bin = tbin;
      @(negedge clk);
      bus.start = 0; bus.a = W'($urandom); bus.b = W'($urandom); bus.bin = 1'($urandom);
      busy_cnt = 0; got = 0;
      for (int k = 0; k < W + 8 && !got; k++) begin
         if (bus.done) got = 1;
         else begin
            if (bus.busy) busy_cnt++;
            if (k == ignore_at) begin
               bus.start = 1; bus.a = W'(1); bus.b = W'(1); bus.bin = 0;
            end else bus.start = 0;
            @(negedge clk);
         end
      end
      bus.start = 0;
      check("done_seen", 32'(got), 32'd1);
      check("busy_cycles", 32'(busy_cnt), 32'(W));
      check("lit_d", 32'(bus.d), 32'(ed));
      check("lit_bout", 32'(bus.bout), 32'(eb));
      check("lit_ov", 32'(bus.ov), 32'(eo));
   endtask

   initial begin
      int dones;
      rst = 1; bus.start = 0; bus.a = '0; bus.b = '0; bus.bin = 0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_d", 32'(bus.d), 32'd0);
      check("rst_bout", 32'(bus.bout), 32'd0);
      check("rst_ov", 32'(bus.ov), 32'd0);
      rst = 0;
      chk_en = 1;
      @(negedge clk);

      run_op(16'h0005, 16'h0003, 0, 16'h0002, 0, 0, -1);
      run_op(16'h0000, 16'h0001, 0, 16'hFFFF, 1, 0, -1);
      run_op(16'h8000, 16'h0001, 0, 16'h7FFF, 0, 1, -1);
      run_op(16'h7FFF, 16'hFFFF, 0, 16'h8000, 1, 1, -1);
      // Ignored start at N+5, then back-to-back accept at N+17.
      run_op(16'h1234, 16'h1234, 1, 16'hFFFF, 1, 0, 4);
      run_op(16'h7FFF, 16'hFFFF, 0, 16'h8000, 1, 1, -1);

      // Reset abort at edge N+8.
      bus.start = 1; bus.a = 16'h0100; bus.b = 16'h0001; bus.bin = 0;
      @(negedge clk);
      bus.start = 0;
      repeat (7) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_d", 32'(bus.d), 32'd0);
      check("abort_bout", 32'(bus.bout), 32'd0);
      check("abort_ov", 32'(bus.ov), 32'd0);
      dones = 0;
      repeat (W + 4) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      check("abort_no_done", 32'(dones), 32'd0);
      run_op(16'h0100, 16'h0001, 0, 16'h00FF, 0, 0, -1);

      // Randomised traffic: frequent starts (many while busy), rare resets.
      for (int i = 0; i < 3000; i++) begin
         rst       = ($urandom_range(0, 299) == 0);
         bus.start = ($urandom_range(0, 2) == 0);
         bus.a     = W'($urandom);
         bus.b     = W'($urandom);
         bus.bin   = 1'($urandom);
         @(negedge clk);
      end
      rst = 0; bus.start = 0;
      repeat (W + 4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
